adder_tree_acc: RTL and testbench

ADDER_TREE_ACC -- requirements
Module: adder_tree_acc

---
 rtl/adder_tree_pkg.sv | 40 ++++
 rtl/adder_tree_stage.sv | 42 ++++
 rtl/adder_tree_acc.sv | 121 ++++++++++++
 tb/tb_adder_tree_acc.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adder_tree_pkg.sv
// Shared constants and elaboration-time helpers for the pipelined adder tree accumulator.
// Level l (1..LEVELS) holds node_cnt(num_in, l) nodes of width dw_in + l.
package adder_tree_pkg;

  typedef struct packed {
    logic vld;
    logic acc;
    logic last;
  } beat_flags_t;

  function automatic int unsigned clog2(input int unsigned n);
    int unsigned r;
    r = 0;
    while ((32'd1 << r) < n) r++;
    return r;
  endfunction

  function automatic int unsigned levels_f(input int unsigned num_in);
    return clog2(num_in);
  endfunction

  function automatic int unsigned dw_out_f(input int unsigned num_in, input int unsigned dw_in,
                                           input int unsigned acc_bits);
    return dw_in + levels_f(num_in) + acc_bits;
  endfunction

  function automatic int unsigned node_cnt(input int unsigned num_in, input int unsigned lvl);
    return (num_in + (32'd1 << lvl) - 1) >> lvl;
  endfunction

  // Bit offset of the first node of level lvl in the flattened inter-stage bus.
  function automatic int unsigned lvl_off(input int unsigned num_in, input int unsigned dw_in,
                                          input int unsigned lvl);
    int unsigned off;
    off = 0;
    for (int unsigned j = 1; j < lvl; j++) off += node_cnt(num_in, j) * (dw_in + j);
    return off;
  endfunction

endpackage

// File: rtl/adder_tree_stage.sv
// One registered adder-tree level: N signed inputs of W bits -> ceil(N/2) sums of W+1 bits.
// A trailing odd input is sign-extended and registered without an adder.
module adder_tree_stage
  import adder_tree_pkg::*;
#(
  parameter int unsigned N = 2,
  parameter int unsigned W = 16,
  localparam int unsigned M = node_cnt(N, 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_en,
  input  logic [N*W-1:0]   i_data,
  output logic [M*(W+1)-1:0] o_data
);

  logic [M*(W+1)-1:0] r_data;
  logic [M*(W+1)-1:0] w_sum;

  for (genvar k = 0; k < M; k++) begin : g_node
    logic signed [W:0] w_a;
    assign w_a = {i_data[2*k*W+W-1], i_data[2*k*W +: W]};
    if (2 * k + 1 < N) begin : g_pair
      logic signed [W:0] w_b;
      assign w_b = {i_data[(2*k+1)*W+W-1], i_data[(2*k+1)*W +: W]};
      assign w_sum[k*(W+1) +: W+1] = w_a + w_b;
    end else begin : g_pass
      assign w_sum[k*(W+1) +: W+1] = w_a;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_data <= '0;
    end else if (i_en) begin
      r_data <= w_sum;
    end
  end

  assign o_data = r_data;

endmodule

// File: rtl/adder_tree_acc.sv
// Pipelined signed adder tree feeding a group accumulator with ready/valid flow control.
// Whole pipeline stalls together while a result waits for out_ready.
module adder_tree_acc
  import adder_tree_pkg::*;
#(
  parameter int unsigned NUM_IN   = 8,
  parameter int unsigned DW_IN    = 16,
  parameter int unsigned ACC_BITS = 8,
  localparam int unsigned LEVELS  = levels_f(NUM_IN),
  localparam int unsigned DW_OUT  = dw_out_f(NUM_IN, DW_IN, ACC_BITS)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_IN*DW_IN-1:0]  in_data,
  input  logic                     in_acc,
  input  logic                     in_last,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic signed [DW_OUT-1:0] out_data,
  output logic [ACC_BITS:0]        out_count
);

  localparam int unsigned TREE_W = DW_IN + LEVELS;
  localparam int unsigned BUS_W  = lvl_off(NUM_IN, DW_IN, LEVELS + 1);
  localparam logic [ACC_BITS:0] GROUP_MAX = {1'b1, {ACC_BITS{1'b0}}};
  localparam logic [ACC_BITS:0] CNT_ONE   = {{ACC_BITS{1'b0}}, 1'b1};

  logic                     w_en;
  logic [BUS_W-1:0]         w_tree;
  logic [TREE_W-1:0]        w_tree_sum;
  logic signed [DW_OUT-1:0] w_tree_ext;
  logic signed [DW_OUT-1:0] w_sum;
  logic [ACC_BITS:0]        w_cnt;
  logic                     w_close;
  beat_flags_t              w_tail;

  beat_flags_t              r_flags [LEVELS];
  logic signed [DW_OUT-1:0] r_acc;
  logic [ACC_BITS:0]        r_cnt;
  logic                     r_out_valid;
  logic signed [DW_OUT-1:0] r_out_data;
  logic [ACC_BITS:0]        r_out_count;

  assign w_en     = !r_out_valid || out_ready;
  assign in_ready = w_en;

  for (genvar l = 1; l <= LEVELS; l++) begin : g_lvl
    localparam int unsigned NI = node_cnt(NUM_IN, l - 1);
    localparam int unsigned WI = DW_IN + l - 1;
    localparam int unsigned NO = node_cnt(NUM_IN, l);
    logic [NI*WI-1:0] w_in;
    if (l == 1) begin : g_first
      assign w_in = in_data;
    end else begin : g_next
      assign w_in = w_tree[lvl_off(NUM_IN, DW_IN, l - 1) +: NI*WI];
    end
    adder_tree_stage #(
      .N(NI),
      .W(WI)
    ) u_stage (
      .clk   (clk),
      .rst   (rst),
      .i_en  (w_en),
      .i_data(w_in),
      .o_data(w_tree[lvl_off(NUM_IN, DW_IN, l) +: NO*(WI+1)])
    );
  end

  // Flags ride alongside the tree so they reach the accumulator with their sum.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < LEVELS; i++) r_flags[i] <= '0;
    end else if (w_en) begin
      r_flags[0] <= beat_flags_t'{vld: in_valid, acc: in_acc, last: in_last};
      for (int i = 1; i < LEVELS; i++) r_flags[i] <= r_flags[i-1];
    end
  end

  assign w_tail     = r_flags[LEVELS-1];
  assign w_tree_sum = w_tree[lvl_off(NUM_IN, DW_IN, LEVELS) +: TREE_W];
  assign w_tree_ext = {{ACC_BITS{w_tree_sum[TREE_W-1]}}, w_tree_sum};
  assign w_sum      = r_acc + w_tree_ext;
  assign w_cnt      = r_cnt + CNT_ONE;
  // A full group closes even without last so the count never wraps.
  assign w_close    = w_tail.last || (w_cnt == GROUP_MAX);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_acc       <= '0;
      r_cnt       <= '0;
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_count <= '0;
    end else if (w_en) begin
      r_out_valid <= 1'b0;
      if (w_tail.vld) begin
        if (!w_tail.acc) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_tree_ext;
          r_out_count <= CNT_ONE;
        end else if (w_close) begin
          r_out_valid <= 1'b1;
          r_out_data  <= w_sum;
          r_out_count <= w_cnt;
          r_acc       <= '0;
          r_cnt       <= '0;
        end else begin
          r_acc <= w_sum;
          r_cnt <= w_cnt;
        end
      end
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_count = r_out_count;

endmodule

// File: tb/tb_adder_tree_acc.sv
// Scoreboard bench for adder_tree_acc: three configurations (8 lanes, 5 lanes, 2 guard bits)
// with a behavioural group model feeding per-instance expectation queues.
module tb_adder_tree_acc;

  typedef struct {
    longint data;
    int     cnt;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // Instance 0: NUM_IN=8, ACC_BITS=8
  logic rst0, iv0, ir0, ia0, il0, ov0, or0;
  logic [127:0] id0;
  logic signed [26:0] od0;
  logic [8:0] oc0;
  // Instance 1: NUM_IN=5, ACC_BITS=8
  logic rst1, iv1, ir1, ia1, il1, ov1, or1;
  logic [79:0] id1;
  logic signed [26:0] od1;
  logic [8:0] oc1;
  // Instance 2: NUM_IN=8, ACC_BITS=2
  logic rst2, iv2, ir2, ia2, il2, ov2, or2;
  logic [127:0] id2;
  logic signed [20:0] od2;
  logic [2:0] oc2;

  adder_tree_acc #(.NUM_IN(8), .DW_IN(16), .ACC_BITS(8)) u_dut0 (
    .clk(clk), .rst(rst0), .in_valid(iv0), .in_ready(ir0), .in_data(id0), .in_acc(ia0),
    .in_last(il0), .out_valid(ov0), .out_ready(or0), .out_data(od0), .out_count(oc0)
  );
  adder_tree_acc #(.NUM_IN(5), .DW_IN(16), .ACC_BITS(8)) u_dut1 (
    .clk(clk), .rst(rst1), .in_valid(iv1), .in_ready(ir1), .in_data(id1), .in_acc(ia1),
    .in_last(il1), .out_valid(ov1), .out_ready(or1), .out_data(od1), .out_count(oc1)
  );
  adder_tree_acc #(.NUM_IN(8), .DW_IN(16), .ACC_BITS(2)) u_dut2 (
    .clk(clk), .rst(rst2), .in_valid(iv2), .in_ready(ir2), .in_data(id2), .in_acc(ia2),
    .in_last(il2), .out_valid(ov2), .out_ready(or2), .out_data(od2), .out_count(oc2)
  );

  int     n_vec = 0;
  int     n_err = 0;
  exp_t   q [3][$];
  longint m_acc [3];
  int     m_cnt [3];

  task automatic check_eq(input string tag, input logic signed [63:0] got,
                          input logic signed [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic int lanes(input int w);
    return (w == 1) ? 5 : 8;
  endfunction

  function automatic int abits(input int w);
    return (w == 2) ? 2 : 8;
  endfunction

  function automatic longint wrap(input longint x, input int bits);
    return (x <<< (64 - bits)) >>> (64 - bits);
  endfunction

  function automatic logic rdy(input int w);
    case (w)
      0:       return ir0;
      1:       return ir1;
      default: return ir2;
    endcase
  endfunction

  task automatic model_push(input int w, input logic [127:0] d, input bit acc, input bit last);
    longint s;
    int dw;
    exp_t e;
    s  = 0;
    dw = 16 + 3 + abits(w);
    for (int i = 0; i < lanes(w); i++) s += longint'($signed(d[i*16 +: 16]));
    if (!acc) begin
      e.data = wrap(s, dw);
      e.cnt  = 1;
      q[w].push_back(e);
    end else begin
      m_acc[w] += s;
      m_cnt[w]++;
      if (last || m_cnt[w] == (1 << abits(w))) begin
        e.data = wrap(m_acc[w], dw);
        e.cnt  = m_cnt[w];
        q[w].push_back(e);
        m_acc[w] = 0;
        m_cnt[w] = 0;
      end
    end
  endtask

  task automatic model_reset(input int w);
    m_acc[w] = 0;
    m_cnt[w] = 0;
    q[w].delete();
  endtask

  task automatic drive(input int w, input logic v, input logic [127:0] d, input logic acc,
                       input logic last);
    case (w)
      0: begin iv0 = v; id0 = d; ia0 = acc; il0 = last; end
      1: begin iv1 = v; id1 = d[79:0]; ia1 = acc; il1 = last; end
      default: begin iv2 = v; id2 = d; ia2 = acc; il2 = last; end
    endcase
  endtask

  // Present a beat from the next falling edge until it is accepted; returns just after that edge.
  task automatic send(input int w, input logic [127:0] d, input bit acc, input bit last);
    bit got;
    got = 1'b0;
    @(negedge clk);
    drive(w, 1'b1, d, acc, last);
    for (int t = 0; t < 50; t++) begin
      #1;
      if (rdy(w)) begin
        got = 1'b1;
        break;
      end
      @(negedge clk);
    end
    if (!got) check_eq("send_timeout", rdy(w), 1);
    else model_push(w, d, acc, last);
    @(posedge clk);
  endtask

  task automatic idle(input int w);
    @(negedge clk);
    drive(w, 1'b0, '0, 1'b0, 1'b0);
  endtask

  task automatic mon(input int w, input logic vld, input logic ordy, input logic irdy,
                     input longint data, input int cnt);
    exp_t e;
    if (vld && ordy) begin
      if (q[w].size() == 0) begin
        check_eq($sformatf("spurious_out%0d", w), vld, 0);
      end else begin
        e = q[w].pop_front();
        check_eq($sformatf("out_data%0d", w), data, e.data);
        check_eq($sformatf("out_count%0d", w), cnt, e.cnt);
      end
    end else if (vld && !ordy) begin
      check_eq($sformatf("stall_in_ready%0d", w), irdy, 0);
      if (q[w].size() != 0) check_eq($sformatf("stall_data%0d", w), data, q[w][0].data);
    end
  endtask

  always begin
    @(negedge clk);
    #1;
    if (!rst0) mon(0, ov0, or0, ir0, longint'(od0), int'(oc0));
    if (!rst1) mon(1, ov1, or1, ir1, longint'(od1), int'(oc1));
    if (!rst2) mon(2, ov2, or2, ir2, longint'(od2), int'(oc2));
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at t=%0t, expected finish", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [127:0] d_seq, d_ones, d_rnd, d_min, d_mix;
    int lat, run, best;
    bit acc, last;

    for (int i = 0; i < 8; i++) begin
      d_seq[i*16 +: 16]  = 16'(i + 1);
      d_ones[i*16 +: 16] = 16'd1;
      d_min[i*16 +: 16]  = 16'h8000;
    end
    d_mix = '0;
    d_mix[79:0] = {16'sd32767, -16'sd400, 16'sd300, -16'sd200, 16'sd100};
    for (int w = 0; w < 3; w++) model_reset(w);
    rst0 = 1; rst1 = 1; rst2 = 1;
    or0 = 1; or1 = 1; or2 = 1;
    for (int w = 0; w < 3; w++) drive(w, 1'b0, '0, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst0 = 0; rst1 = 0; rst2 = 0;
    #1;
    check_eq("rst_out_valid", ov0, 0);
    check_eq("rst_out_data", od0, 0);
    check_eq("rst_out_count", oc0, 0);
    check_eq("rst_in_ready", ir0, 1);
    check_eq("rst_out_valid2", ov2, 0);

    // Standalone 1..8 = 36, valid on the 4th edge counting the accepting edge.
    send(0, d_seq, 1'b0, 1'b0);
    lat = 1;
    for (int t = 0; t < 20; t++) begin
      @(negedge clk);
      drive(0, 1'b0, '0, 1'b0, 1'b0);
      #1;
      if (ov0) break;
      lat++;
    end
    check_eq("latency", lat, 4);
    repeat (3) @(negedge clk);

    // Three-beat group of ones, last on the third: one result 24 / 3.
    send(0, d_ones, 1'b1, 1'b0);
    send(0, d_ones, 1'b1, 1'b0);
    send(0, d_ones, 1'b1, 1'b1);
    idle(0);
    repeat (8) @(negedge clk);
    check_eq("drain_group", q[0].size(), 0);

    // Random mixed stream with a 5-cycle downstream stall.
    fork
      begin
        for (int n = 0; n < 40; n++) begin
          for (int i = 0; i < 8; i++) d_rnd[i*16 +: 16] = 16'($urandom);
          acc  = ($urandom_range(0, 2) != 0);
          last = acc && ($urandom_range(0, 3) == 0);
          send(0, d_rnd, acc, last);
        end
        send(0, d_ones, 1'b1, 1'b1);
        idle(0);
      end
      begin
        repeat (8) @(negedge clk);
        or0 = 1'b0;
        repeat (5) @(negedge clk);
        or0 = 1'b1;
      end
    join
    repeat (10) @(negedge clk);
    check_eq("drain_stream", q[0].size(), 0);

    // Six back-to-back standalone beats must give six consecutive results.
    best = 0;
    fork
      begin
        for (int n = 0; n < 6; n++) send(0, d_seq, 1'b0, 1'b0);
        idle(0);
      end
      begin
        run = 0;
        repeat (16) begin
          @(negedge clk);
          #1;
          if (ov0) run++;
          else run = 0;
          if (run > best) best = run;
        end
      end
    join
    check_eq("no_bubble_run", best, 6);
    check_eq("drain_bubble", q[0].size(), 0);

    // Five lanes of -32768 and a mixed odd-lane vector.
    send(1, d_min, 1'b0, 1'b0);
    send(1, d_mix, 1'b0, 1'b0);
    idle(1);
    repeat (8) @(negedge clk);
    check_eq("drain_5lane", q[1].size(), 0);

    // Two guard bits: fourth beat forces a split at count 4.
    for (int n = 0; n < 4; n++) send(2, d_ones, 1'b1, 1'b0);
    idle(2);
    repeat (8) @(negedge clk);
    check_eq("drain_split", q[2].size(), 0);
    send(2, d_ones, 1'b1, 1'b0);
    @(negedge clk);
    drive(2, 1'b1, d_ones, 1'b1, 1'b0);
    rst2 = 1'b1;
    model_reset(2);
    @(posedge clk);
    @(negedge clk);
    rst2 = 1'b0;
    drive(2, 1'b0, '0, 1'b0, 1'b0);
    #1;
    check_eq("midgrp_rst_valid", ov2, 0);
    check_eq("midgrp_rst_count", oc2, 0);
    repeat (6) @(negedge clk);
    // Partial sums before reset must not leak into the next group.
    send(2, d_ones, 1'b1, 1'b1);
    idle(2);
    repeat (8) @(negedge clk);
    check_eq("drain_after_rst", q[2].size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
